// File: rtl/if_id_register.sv
// IF/ID pipeline register for the 5-stage MIPS pipeline.
// Holds the fetched instruction and PC+4 for the ID stage and supports
// stall (hold), flush (bubble) and fetch-not-ready (bubble) behaviour.
// A 2-bit control FSM (EMPTY/LOADED/HELD/FLUSHED) is exported for debug.
// Optional feature macro: IF_ID_PERF_COUNT_EN adds saturating stall and
// flush counters as extra outputs.
module if_id_register #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] instruction_if,
  input  logic [DATA_WIDTH-1:0] pc_plus4_if,
  input  logic                  fetch_valid_if,
  input  logic                  stall_id,
  input  logic                  flush_id,
  output logic [DATA_WIDTH-1:0] current_instruction_if_id,
  output logic [DATA_WIDTH-1:0] pc_plus4_if_id,
  output logic                  valid_if_id,
  output logic [1:0]            state_if_id
`ifdef IF_ID_PERF_COUNT_EN
  ,
  output logic [15:0]           stall_cycles_if_id,
  output logic [15:0]           flush_count_if_id
`endif
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADED  = 2'd1,
    HELD    = 2'd2,
    FLUSHED = 2'd3
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   instruction;
  logic [DATA_WIDTH-1:0]   pc_plus4;
  logic                    valid;

  // Pipeline register and control FSM; priority is flush > stall > load/bubble.
  // The instruction word is only taken from IF when fetch_valid_if is high,
  // so an undefined IF word never reaches the ID outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      instruction <= NOP_WORD;
      pc_plus4    <= PC_RESET;
      valid       <= 1'b0;
    end else if (flush_id) begin
      state       <= FLUSHED;
      instruction <= NOP_WORD;
      valid       <= 1'b0;
    end else if (stall_id) begin
      // Contents hold; only a real instruction counts as held.
      state <= valid ? HELD : EMPTY;
    end else if (fetch_valid_if) begin
      state       <= LOADED;
      instruction <= instruction_if;
      pc_plus4    <= pc_plus4_if;
      valid       <= 1'b1;
    end else begin
      state       <= EMPTY;
      instruction <= NOP_WORD;
      valid       <= 1'b0;
    end
  end

  assign current_instruction_if_id = instruction;
  assign pc_plus4_if_id            = pc_plus4;
  assign valid_if_id               = valid;
  assign state_if_id               = state;

`ifdef IF_ID_PERF_COUNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  // Saturating event counters: stalls that are not overridden by a flush,
  // and every flush edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (flush_id) begin
        if (flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
      end else if (stall_id) begin
        if (stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

  assign stall_cycles_if_id = stall_cycles;
  assign flush_count_if_id  = flush_count;
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Self-checking bench for if_id_register: directed test-plan steps followed
// by randomized traffic, compared against a behavioural model of the
// stage-register rules. Perf-counter checks are active when
// IF_ID_PERF_COUNT_EN is defined.
module tb_if_id_register;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] PCRST = 32'h0000_0000;
  localparam int S_EMPTY = 0, S_LOADED = 1, S_HELD = 2, S_FLUSHED = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instruction_if;
  logic [31:0] pc_plus4_if;
  logic        fetch_valid_if;
  logic        stall_id;
  logic        flush_id;
  logic [31:0] current_instruction_if_id;
  logic [31:0] pc_plus4_if_id;
  logic        valid_if_id;
  logic [1:0]  state_if_id;
`ifdef IF_ID_PERF_COUNT_EN
  logic [15:0] stall_cycles_if_id;
  logic [15:0] flush_count_if_id;
`endif

  always #5 clock = ~clock;

  if_id_register dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .instruction_if            (instruction_if),
    .pc_plus4_if               (pc_plus4_if),
    .fetch_valid_if            (fetch_valid_if),
    .stall_id                  (stall_id),
    .flush_id                  (flush_id),
    .current_instruction_if_id (current_instruction_if_id),
    .pc_plus4_if_id            (pc_plus4_if_id),
    .valid_if_id               (valid_if_id),
    .state_if_id               (state_if_id)
`ifdef IF_ID_PERF_COUNT_EN
    ,
    .stall_cycles_if_id        (stall_cycles_if_id),
    .flush_count_if_id         (flush_count_if_id)
`endif
  );

  // Behavioural model of what ID should currently see.
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  int          m_state;
  int          m_stalls;
  int          m_flushes;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".instr"}, current_instruction_if_id, m_instr);
    check({tag, ".pc"},    pc_plus4_if_id, m_pc);
    check({tag, ".valid"}, {31'd0, valid_if_id}, {31'd0, m_valid});
    check({tag, ".state"}, {30'd0, state_if_id}, 32'(m_state));
    check({tag, ".nox"},
          {31'd0, $isunknown({current_instruction_if_id, pc_plus4_if_id, valid_if_id, state_if_id})},
          32'd0);
`ifdef IF_ID_PERF_COUNT_EN
    check({tag, ".stalls"},  {16'd0, stall_cycles_if_id}, 32'(m_stalls));
    check({tag, ".flushes"}, {16'd0, flush_count_if_id},  32'(m_flushes));
`endif
  endtask

  task automatic model_reset();
    m_instr   = NOP;
    m_pc      = PCRST;
    m_valid   = 1'b0;
    m_state   = S_EMPTY;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // Called a little after a rising edge; asserts reset between edges.
  task automatic apply_reset(input string tag);
    #1 reset_n = 1'b0;
    model_reset();
    #1 compare_all(tag);
    #1 reset_n = 1'b1;
  endtask

  // One clock edge: drive inputs, advance the model, check after the edge.
  task automatic step(input string tag, input bit stall, input bit flush, input bit fv,
                      input logic [31:0] ins, input logic [31:0] pc, input bit quiet);
    stall_id       = stall;
    flush_id       = flush;
    fetch_valid_if = fv;
    instruction_if = ins;
    pc_plus4_if    = pc;
    if (flush) begin
      m_instr   = NOP;
      m_valid   = 1'b0;
      m_state   = S_FLUSHED;
      m_flushes = (m_flushes < 65535) ? m_flushes + 1 : 65535;
    end else if (stall) begin
      m_state  = m_valid ? S_HELD : S_EMPTY;
      m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
    end else if (fv) begin
      m_instr = ins;
      m_pc    = pc;
      m_valid = 1'b1;
      m_state = S_LOADED;
    end else begin
      m_instr = NOP;
      m_valid = 1'b0;
      m_state = S_EMPTY;
    end
    @(posedge clock);
    #1;
    compare_all(tag);
    if (!quiet)
      $display("%-10s stall=%0b flush=%0b fv=%0b in=%h pc=%h -> instr=%h pc=%h valid=%0b state=%0d",
               tag, stall, flush, fv, ins, pc, current_instruction_if_id, pc_plus4_if_id,
               valid_if_id, state_if_id);
  endtask

  initial begin
    reset_n        = 1'b0;
    instruction_if = 32'h0;
    pc_plus4_if    = 32'h0;
    fetch_valid_if = 1'b0;
    stall_id       = 1'b0;
    flush_id       = 1'b0;
    model_reset();
    #1 compare_all("reset0");
    #1 reset_n = 1'b1;

    // Reset then normal load
    step("load", 0, 0, 1, 32'h2008_FFFC, 32'h0000_0004, 0);
    check("signext_lo", {16'd0, current_instruction_if_id[15:0]}, 32'h0000_FFFC);
    check("load_state", {30'd0, state_if_id}, 32'd1);

    // Stall hold
    step("load2", 0, 0, 1, 32'h8C09_0010, 32'h0000_0008, 0);
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 1, 32'hAAAA_AAAA, 32'h0000_000C, 0);
    check("hold_instr", current_instruction_if_id, 32'h8C09_0010);
    check("hold_state", {30'd0, state_if_id}, 32'd2);
    step("release", 0, 0, 1, 32'hAAAA_AAAA, 32'h0000_000C, 0);
    check("release_instr", current_instruction_if_id, 32'hAAAA_AAAA);

    // Flush beats stall
    step("flushstall", 1, 1, 1, 32'h1111_2222, 32'h0000_0010, 0);
    check("flush_state", {30'd0, state_if_id}, 32'd3);
    check("flush_pc", pc_plus4_if_id, 32'h0000_000C);
    step("postflush", 0, 0, 1, 32'h1234_5678, 32'h0000_0014, 0);

    // Fetch bubble with undefined IF word
    step("bubble", 0, 0, 0, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 0);
    check("bubble_instr", current_instruction_if_id, 32'h0000_0000);

    // Async reset while HELD
    step("load3", 0, 0, 1, 32'hDEAD_BEEF, 32'h0000_0018, 0);
    step("stall2", 1, 0, 1, 32'h5555_5555, 32'h0000_001C, 0);
    step("stall3", 1, 0, 1, 32'h5555_5555, 32'h0000_001C, 0);
    apply_reset("rst_held");
    check("rst_held_valid", {31'd0, valid_if_id}, 32'd0);
    step("afterrst", 0, 0, 1, 32'h0042_0042, 32'h0000_0020, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      bit s, f, v;
      s = ($urandom_range(3) == 0);
      f = ($urandom_range(7) == 0);
      v = ($urandom_range(3) != 0);
      step("rand", s, f, v, $urandom, $urandom, 0);
    end

`ifdef IF_ID_PERF_COUNT_EN
    // Counter values for a known sequence
    apply_reset("rst_perf");
    for (int i = 0; i < 5; i++) step("pstall", 1, 0, 1, 32'h0, 32'h0, 0);
    for (int i = 0; i < 2; i++) step("pflush", 0, 1, 1, 32'h0, 32'h0, 0);
    check("perf_stalls",  {16'd0, stall_cycles_if_id}, 32'd5);
    check("perf_flushes", {16'd0, flush_count_if_id},  32'd2);

    // Saturation: count up to 16'hFFFE, then 3 more stalls
    apply_reset("rst_sat");
    for (int i = 0; i < 65534; i++) step("satfill", 1, 0, 0, 32'h0, 32'h0, 1);
    check("sat_pre", {16'd0, stall_cycles_if_id}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) step("satstall", 1, 0, 0, 32'h0, 32'h0, 0);
    check("sat_post", {16'd0, stall_cycles_if_id}, 32'h0000_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_register.md
Name: if_id_register

Overview:
- IF/ID pipeline register of the 5-stage MIPS pipeline.
- Captures the fetched instruction and PC+4 from the IF stage and presents them to ID.
- ID consumers include the sign-extension unit, which takes bits [15:0] of the instruction output, the register file and the control unit.
- Handles stall (hold), flush (bubble insertion) and fetch-not-ready (bubble); tracks a valid bit and a small control FSM.

Parameters:
- DATA_WIDTH, 32, width of instruction and PC words.
- NOP_WORD, 32'h0000_0000, encoding injected on bubble/flush (sll $0,$0,0).
- PC_RESET, 32'h0000_0000, PC+4 value held after reset.

Ports:
- clock  in  1  pipeline clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- instruction_if  in  DATA_WIDTH  instruction word from instruction memory.
- pc_plus4_if  in  DATA_WIDTH  PC+4 from IF adder.
- fetch_valid_if  in  1  IF word valid this cycle.
- stall_id  in  1  hazard unit: hold IF/ID contents.
- flush_id  in  1  branch/jump taken: discard IF/ID contents.
- current_instruction_if_id  out  DATA_WIDTH  instruction to ID; bits [15:0] feed sign extension.
- pc_plus4_if_id  out  DATA_WIDTH  PC+4 to ID (branch target adder).
- valid_if_id  out  1  ID holds a real instruction.
- state_if_id  out  2  FSM state, debug visibility.

Behaviour:
- Reset (reset_n=0, asynchronous, no clock needed):
  - current_instruction_if_id=NOP_WORD, pc_plus4_if_id=PC_RESET, valid_if_id=0, state=EMPTY.
- All updates on rising clock edge. Latency IF -> ID outputs: 1 cycle. Outputs are registered; no combinational path from inputs to outputs.
- Per-edge priority: flush_id > stall_id > load.
  - flush_id=1: instruction<=NOP_WORD, valid<=0, pc_plus4 unchanged, state<=FLUSHED. Applies even if stall_id=1 in the same cycle.
  - stall_id=1 (no flush): all outputs hold; state<=HELD if valid=1, else stays EMPTY.
  - Otherwise, fetch_valid_if=1: instruction<=instruction_if, pc_plus4<=pc_plus4_if, valid<=1, state<=LOADED.
  - Otherwise, fetch_valid_if=0: instruction<=NOP_WORD, valid<=0, pc_plus4 held, state<=EMPTY.
- FSM states (2-bit encoding): EMPTY=0, LOADED=1, HELD=2, FLUSHED=3.
  - FLUSHED lasts exactly one cycle unless flush_id is reasserted.
  - From FLUSHED, the next edge follows the normal rules above.
  - From HELD, deasserting stall_id loads the new IF word, or a bubble if fetch_valid_if=0.
  - An instruction in HELD is never lost or duplicated: on release exactly one new word enters.
- valid_if_id=0 implies current_instruction_if_id==NOP_WORD in every state.
- Reset asserted mid-stall or mid-flush returns to reset values immediately; the first edge after release follows normal rules.
- X on instruction_if while fetch_valid_if=0 must not propagate to outputs.

Optional Feature:
- Macro: IF_ID_PERF_COUNT_EN
- Enabled:
  - Adds output stall_cycles_if_id [15:0]: counts edges with stall_id=1 and flush_id=0.
  - Adds output flush_count_if_id [15:0]: counts edges with flush_id=1.
  - Both counters saturate at 16'hFFFF (no wrap) and are cleared by reset_n.
- Disabled: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then normal load:
  - Stimulus: release reset; instruction_if=32'h2008_FFFC, pc_plus4_if=32'h0000_0004, fetch_valid_if=1.
  - Response: after 1 edge, outputs carry 32'h2008_FFFC / 32'h4, valid=1, state=LOADED; ID sign extension sees 16'hFFFC.
- Stall hold:
  - Stimulus: after loading 32'h8C09_0010, hold stall_id=1 for 3 edges while IF presents 32'hAAAA_AAAA.
  - Response: outputs stay 32'h8C09_0010, state=HELD. Release stall: the next edge loads 32'hAAAA_AAAA.
- Flush beats stall:
  - Stimulus: stall_id=1 and flush_id=1 on the same edge.
  - Response: instruction=0, valid=0, state=FLUSHED. The following edge with fetch_valid_if=1 loads normally.
- Fetch bubble:
  - Stimulus: fetch_valid_if=0 with instruction_if=X.
  - Response: instruction=0, valid=0, state=EMPTY, no X on any output.
- Async reset mid-stall:
  - Stimulus: assert reset_n=0 between clock edges while in HELD.
  - Response: outputs go to reset values before the next edge.
- Perf counters (with IF_ID_PERF_COUNT_EN):
  - Stimulus: 5 stall edges, then 2 flush edges.
  - Response: stall_cycles_if_id=5, flush_count_if_id=2.
  - Stimulus: preload stall_cycles_if_id to 16'hFFFE, apply 3 stall edges.
  - Response: stall_cycles_if_id reads 16'hFFFF.
